rps_match: RTL
==============

Name: rps_match

Overview:
- Parametrised successor to the single-round rock-paper-scissors game on the iCEBreaker.
- Plays a best-of match: first player to ROUNDS_TO_WIN round wins takes the match. It uses debounced buttons, an LFSR-driven computer choice with no bias, a timed result display, and per-player score counters.
- Sits between the board buttons and the LED outputs. A board-level top instantiates it.

Parameters:
- DEBOUNCE_CYCLES, 16'd12000: cycles a button must be stable before the debounced level changes (1 ms at 12 MHz).
- HOLD_CYCLES, 24'd6000000: cycles a round result is shown (0.5 s).
- ROUNDS_TO_WIN, 3: round wins needed to win the match; legal range 1..7.
- LFSR_SEED, 16'hACE1: reset value of the LFSR; must be nonzero.

Ports:
- CLK, in, 1: system clock.
- RST_N, in, 1: synchronous active-low reset.
- BTN_ROCK, in, 1: raw button, active-high, asynchronous to CLK.
- BTN_PAPER, in, 1: raw button, active-high.
- BTN_SCISSORS, in, 1: raw button, active-high.
- RESULT, out, 3: round result. 3'b001 person wins, 3'b010 computer wins, 3'b100 tie, 3'b111 idle/blank.
- COMP_CHOICE, out, 2: last computer choice (0 none, 1 rock, 2 paper, 3 scissors).
- PERSON_SCORE, out, 3: person round wins in the current match.
- COMP_SCORE, out, 3: computer round wins in the current match.
- MATCH_OVER, out, 1: high while the match winner is shown.
- MATCH_WINNER, out, 1: 0 person, 1 computer; valid only while MATCH_OVER=1.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - FSM goes to IDLE.
  - RESULT=7, COMP_CHOICE=0, both scores 0, MATCH_OVER=0, MATCH_WINNER=0, LFSR=LFSR_SEED.
  - Debounce counters are cleared and debounced levels are 0.
  - Reset mid-round or mid-hold aborts with no score update.
- Input path:
  - Each raw button passes a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current level.
  - Press = rising edge of a debounced level.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Steps every cycle regardless of state.
- FSM states and transitions:
  - IDLE: on a cycle with exactly one press edge, latch the person choice and go to DRAW. Two or three simultaneous edges are ignored (stay IDLE). Edges while not in IDLE are ignored.
  - DRAW: if lfsr[1:0]!=0, latch it as COMP_CHOICE and go to JUDGE; otherwise stay and retry next cycle.
  - JUDGE (1 cycle):
    - Compute the result with the standard rules; equal choices = tie.
    - Increment the winner's score (saturating at 7). A tie changes no score.
    - Load the hold timer with HOLD_CYCLES-1 and go to SHOW.
    - RESULT updates on the JUDGE→SHOW edge.
  - SHOW: count the timer down to 0. Then:
    - If either score == ROUNDS_TO_WIN: go to OVER, set MATCH_OVER=1, set MATCH_WINNER.
    - Otherwise: go to RELEASE.
  - RELEASE: RESULT stays shown until all debounced levels are 0, then RESULT=7 and go to IDLE.
    - A button held through SHOW therefore cannot start a new round.
  - OVER:
    - RESULT keeps the final round result; scores are frozen.
    - After all buttons are released, the next press edge clears the scores, MATCH_OVER and RESULT (to 7) and goes to IDLE.
    - That press is not played as a round.
- Latency: press edge to RESULT valid is 2 cycles minimum (DRAW hit), plus 1 per DRAW retry.
- HOLD_CYCLES=1: SHOW lasts exactly 1 cycle.

Decomposition:
- Package rps_pkg holds:
  - choice constants NONE/ROCK/PAPER/SCISSORS;
  - result codes PERSON_WINS/COMPUTER_WINS/TIE/BLANK;
  - FSM state encoding;
  - an rps_judge function (person, computer → result).
- One sub-module, rps_debounce: synchroniser plus counter per button, parameter DEBOUNCE_CYCLES, output level and rise pulse. It is instantiated 3×.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, ROUNDS_TO_WIN=2. The bench carries a reference LFSR model.
1. Reset: hold RST_N=0 for 3 cycles → RESULT=7, scores 0, MATCH_OVER=0, COMP_CHOICE=0.
2. Bounce: toggle BTN_ROCK every 2 cycles for 20 cycles, then hold high → exactly one round played; RESULT matches rps_judge(ROCK, model COMP_CHOICE) 2+retries cycles after the debounced edge.
3. Simultaneous: raise BTN_PAPER and BTN_SCISSORS in the same cycle → no round, FSM stays IDLE, RESULT=7.
4. Held button: hold BTN_ROCK through SHOW → no second round until release; RESULT returns to 7 one cycle after the debounced release.
5. Match: force outcomes via the LFSR model to reach 2 person wins → MATCH_OVER=1, MATCH_WINNER=0, PERSON_SCORE=2. The next press after release clears the scores without playing a round.
6. Reset mid-SHOW: assert RST_N at timer=3 → all outputs return to reset values next cycle and the scores are not incremented again.

Source files
------------

// File: rtl/rps_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rps_pkg
//  Purpose  : Shared choice/result codes, FSM encoding and helper functions
//             for the rock-paper-scissors match controller.
//  Revision : 1.0
// ============================================================================
package rps_pkg;

    localparam logic [1:0] NONE     = 2'd0;
    localparam logic [1:0] ROCK     = 2'd1;
    localparam logic [1:0] PAPER    = 2'd2;
    localparam logic [1:0] SCISSORS = 2'd3;

    localparam logic [2:0] PERSON_WINS   = 3'b001;
    localparam logic [2:0] COMPUTER_WINS = 3'b010;
    localparam logic [2:0] TIE           = 3'b100;
    localparam logic [2:0] BLANK         = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAW    = 3'd1,
        ST_JUDGE   = 3'd2,
        ST_SHOW    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_OVER    = 3'd5
    } state_t;

    function automatic logic [2:0] rps_judge(input logic [1:0] person,
                                             input logic [1:0] computer);
        logic [2:0] res;
        if (person == computer) begin
            res = TIE;
        end else if ((person == ROCK     && computer == SCISSORS) ||
                     (person == PAPER    && computer == ROCK)     ||
                     (person == SCISSORS && computer == PAPER)) begin
            res = PERSON_WINS;
        end else begin
            res = COMPUTER_WINS;
        end
        return res;
    endfunction

    // Right-shifting Galois form of x^16+x^14+x^13+x^11
    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        logic [15:0] nxt;
        nxt = {1'b0, value[15:1]};
        if (value[0]) begin
            nxt = nxt ^ 16'hB400;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rps_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : rps_debounce
//  Purpose  : Two-flop synchroniser plus stability counter for one button;
//             emits the debounced level and a rising-edge pulse.
//  Revision : 1.0
// ============================================================================
module rps_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic        sync1;
    logic        sync2;
    logic [15:0] count;
    logic        flip;

    // The pulse coincides with the clock edge that raises the level
    assign flip = (sync2 != level) && (count == DEBOUNCE_CYCLES - 16'd1);
    assign rise = flip && sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= 16'd0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (flip) begin
                    level <= sync2;
                    count <= 16'd0;
                end else begin
                    count <= count + 16'd1;
                end
            end else begin
                count <= 16'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rps_match.sv
`default_nettype none
// ============================================================================
//  Module   : rps_match
//  Purpose  : Best-of rock-paper-scissors match against an LFSR opponent with
//             debounced buttons, timed result display and score counters.
//  Revision : 1.0
// ============================================================================
module rps_match
    import rps_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd12000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd6000000,
    parameter int          ROUNDS_TO_WIN   = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_ROCK,
    input  logic       BTN_PAPER,
    input  logic       BTN_SCISSORS,
    output logic [2:0] RESULT,
    output logic [1:0] COMP_CHOICE,
    output logic [2:0] PERSON_SCORE,
    output logic [2:0] COMP_SCORE,
    output logic       MATCH_OVER,
    output logic       MATCH_WINNER
);

    localparam logic [2:0] WIN_SCORE = ROUNDS_TO_WIN[2:0];

    logic [2:0]  btn_raw;
    logic [2:0]  level;
    logic [2:0]  rise;
    state_t      state;
    logic [15:0] lfsr;
    logic [1:0]  person;
    logic [23:0] hold;
    logic        armed;

    assign btn_raw = {BTN_SCISSORS, BTN_PAPER, BTN_ROCK};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            rps_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (CLK),
                .rst_n(RST_N),
                .btn  (btn_raw[i]),
                .level(level[i]),
                .rise (rise[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            lfsr         <= LFSR_SEED;
            person       <= NONE;
            hold         <= 24'd0;
            armed        <= 1'b0;
            RESULT       <= BLANK;
            COMP_CHOICE  <= NONE;
            PERSON_SCORE <= 3'd0;
            COMP_SCORE   <= 3'd0;
            MATCH_OVER   <= 1'b0;
            MATCH_WINNER <= 1'b0;
        end else begin
            lfsr <= lfsr_step(lfsr);
            case (state)
                ST_IDLE: begin
                    // Only a lone press starts a round; chords are ignored
                    case (rise)
                        3'b001: begin person <= ROCK;     state <= ST_DRAW; end
                        3'b010: begin person <= PAPER;    state <= ST_DRAW; end
                        3'b100: begin person <= SCISSORS; state <= ST_DRAW; end
                        default: ;
                    endcase
                end
                ST_DRAW: begin
                    // Rejecting 0 keeps the three choices equally likely
                    if (lfsr[1:0] != NONE) begin
                        COMP_CHOICE <= lfsr[1:0];
                        state       <= ST_JUDGE;
                    end
                end
                ST_JUDGE: begin
                    RESULT <= rps_judge(person, COMP_CHOICE);
                    case (rps_judge(person, COMP_CHOICE))
                        PERSON_WINS: begin
                            if (PERSON_SCORE != 3'd7) PERSON_SCORE <= PERSON_SCORE + 3'd1;
                        end
                        COMPUTER_WINS: begin
                            if (COMP_SCORE != 3'd7) COMP_SCORE <= COMP_SCORE + 3'd1;
                        end
                        default: ;
                    endcase
                    hold  <= HOLD_CYCLES - 24'd1;
                    state <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (hold != 24'd0) begin
                        hold <= hold - 24'd1;
                    end else if (PERSON_SCORE == WIN_SCORE || COMP_SCORE == WIN_SCORE) begin
                        MATCH_OVER   <= 1'b1;
                        MATCH_WINNER <= (COMP_SCORE == WIN_SCORE);
                        armed        <= 1'b0;
                        state        <= ST_OVER;
                    end else begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (level == 3'b000) begin
                        RESULT <= BLANK;
                        state  <= ST_IDLE;
                    end
                end
                ST_OVER: begin
                    // A button still held from the final round must not restart
                    if (level == 3'b000) begin
                        armed <= 1'b1;
                    end
                    if (armed && (rise != 3'b000)) begin
                        PERSON_SCORE <= 3'd0;
                        COMP_SCORE   <= 3'd0;
                        MATCH_OVER   <= 1'b0;
                        RESULT       <= BLANK;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
